// File: rtl/ercm_pkg.sv
// Shared types and constants for the ERCM8 approximate-multiplier sharing logic.
// The op struct carries an id wide enough for the largest supported requester count.
package ercm_pkg;
  localparam int ERCM_W       = 8;
  localparam int ERCM_PW      = 16;
  localparam int ERCM_MW      = 7;
  localparam int ERCM_IDW_MAX = 3;
  localparam logic [ERCM_MW-1:0] MASK_EXACT = 7'h7F;

  typedef struct packed {
    logic [ERCM_IDW_MAX-1:0] id;
    logic [ERCM_W-1:0]       a;
    logic [ERCM_W-1:0]       b;
    logic [ERCM_MW-1:0]      mask;
  } ercm_op_t;
endpackage

// File: rtl/ercm8_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above ptr (wrapping).
// Produces a one-hot grant plus its encoded index; nothing is granted when en is low.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  id
);
  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt   = '0;
    id    = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        id       = idx;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ercm8_share_ctrl.sv
// Shares one external ERCM8 multiplier among NREQ requesters: round-robin accept,
// operand register (drives mul_*), result register (drives rsp_*), per-requester mask table.
import ercm_pkg::*;

module ercm8_share_ctrl #(
  parameter int                 NREQ     = 4,
  parameter int                 IDW      = 2,
  parameter logic [ERCM_MW-1:0] MASK_RST = 7'h7F
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  input  logic                cfg_we,
  input  logic [IDW-1:0]      cfg_id,
  input  logic [ERCM_MW-1:0]  cfg_mask,
  output logic [ERCM_W-1:0]   mul_a,
  output logic [ERCM_W-1:0]   mul_b,
  output logic [ERCM_MW-1:0]  mul_mask,
  input  logic [ERCM_PW-1:0]  mul_dat,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [ERCM_PW-1:0]  rsp_dat,
  output logic [15:0]         op_cnt
);
  logic [NREQ-1:0][ERCM_W-1:0]  a_v, b_v;
  logic [NREQ-1:0][ERCM_MW-1:0] mask_tbl_q, mask_tbl_d;
  logic [IDW-1:0]               ptr_q, ptr_d;
  ercm_op_t                     s1_q, s1_d;
  logic                         s1_v_q, s1_v_d;
  logic                         s2_v_q, s2_v_d;
  logic [IDW-1:0]               s2_id_q, s2_id_d;
  logic [ERCM_PW-1:0]           s2_dat_q, s2_dat_d;
  logic [15:0]                  op_cnt_q, op_cnt_d;

  logic                         s1_ld, s2_ld, any_gnt, cfg_ok;
  logic [NREQ-1:0]              gnt;
  logic [IDW-1:0]               gnt_id;
  logic                         unused_id;

  assign a_v = req_a;
  assign b_v = req_b;

  // Result stage advances when it is empty or being drained; operand stage follows it.
  assign s2_ld = s1_v_q & (~s2_v_q | rsp_ready);
  assign s1_ld = ~s1_v_q | s2_ld;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .en  (s1_ld),
    .gnt (gnt),
    .id  (gnt_id)
  );

  assign any_gnt   = |gnt;
  assign req_ready = gnt;
  assign cfg_ok    = ({1'b0, cfg_id} < (IDW+1)'(NREQ));

  always_comb begin
    s1_v_d = s1_v_q;
    s1_d   = s1_q;
    ptr_d  = ptr_q;
    if (s1_ld) begin
      s1_v_d = any_gnt;
      if (any_gnt) begin
        s1_d.id   = ERCM_IDW_MAX'(gnt_id);
        s1_d.a    = a_v[gnt_id];
        s1_d.b    = b_v[gnt_id];
        s1_d.mask = mask_tbl_q[gnt_id];
        ptr_d     = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
      end
    end
  end

  always_comb begin
    s2_v_d   = s2_v_q;
    s2_id_d  = s2_id_q;
    s2_dat_d = s2_dat_q;
    if (s2_ld) begin
      s2_v_d   = 1'b1;
      s2_id_d  = s1_q.id[IDW-1:0];
      s2_dat_d = mul_dat;
    end else if (rsp_ready) begin
      s2_v_d   = 1'b0;
    end
  end

  // Table reads above see the pre-write value, so a same-cycle accept keeps the old mask.
  always_comb begin
    mask_tbl_d = mask_tbl_q;
    if (cfg_we && cfg_ok) mask_tbl_d[cfg_id] = cfg_mask;
    op_cnt_d = op_cnt_q + 16'(s2_v_q & rsp_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_tbl_q <= {NREQ{MASK_RST}};
      ptr_q      <= '0;
      s1_q       <= '0;
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      s2_id_q    <= '0;
      s2_dat_q   <= '0;
      op_cnt_q   <= '0;
    end else begin
      mask_tbl_q <= mask_tbl_d;
      ptr_q      <= ptr_d;
      s1_q       <= s1_d;
      s1_v_q     <= s1_v_d;
      s2_v_q     <= s2_v_d;
      s2_id_q    <= s2_id_d;
      s2_dat_q   <= s2_dat_d;
      op_cnt_q   <= op_cnt_d;
    end
  end

  assign unused_id = ^s1_q.id;

  assign mul_a     = s1_q.a;
  assign mul_b     = s1_q.b;
  assign mul_mask  = s1_q.mask;
  assign rsp_valid = s2_v_q;
  assign rsp_id    = s2_id_q;
  assign rsp_dat   = s2_dat_q;
  assign op_cnt    = op_cnt_q;
endmodule

// File: tb/tb_ercm8_share_ctrl.sv
// Bench for ercm8_share_ctrl: directed scenarios with literal expectations plus a
// queue-based model checked every cycle. Supplies the ERCM8 product on mul_dat.
module tb_ercm8_share_ctrl;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       req_valid = '0;
  logic [3:0]       req_ready;
  logic [3:0][7:0]  op_a = '0, op_b = '0;
  logic             cfg_we = 1'b0;
  logic [1:0]       cfg_id = '0;
  logic [6:0]       cfg_mask = '0;
  logic [7:0]       mul_a, mul_b;
  logic [6:0]       mul_mask;
  logic [15:0]      mul_dat;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [1:0]       rsp_id;
  logic [15:0]      rsp_dat, op_cnt;

  int               n_pass = 0, n_tot = 0;
  logic [3:0]       acc = '0;

  always #5 clk = ~clk;

  ercm8_share_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(op_a), .req_b(op_b), .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_mask(cfg_mask),
    .mul_a(mul_a), .mul_b(mul_b), .mul_mask(mul_mask), .mul_dat(mul_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_dat(rsp_dat),
    .op_cnt(op_cnt)
  );

  // ERCM8 behaviour: exact product with the low 7 product columns gated by the mask.
  function automatic logic [15:0] ercm8(input logic [7:0] a, input logic [7:0] b, input logic [6:0] m);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    return p & {9'h1FF, m};
  endfunction

  assign mul_dat = ercm8(mul_a, mul_b, mul_mask);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: ops in flight as an ordered queue; 'out' marks the one presented on rsp_*.
  typedef struct {
    logic [1:0] id;
    logic [7:0] a, b;
    logic [6:0] m;
    bit         out;
  } mop_t;
  mop_t       pipe[$];
  logic [6:0] mtbl[4];
  logic [1:0] mptr;
  logic [15:0] mcnt;

  always @(negedge clk or posedge rst) begin
    logic       exp_rv, drain, allow, found;
    logic [3:0] eg;
    logic [1:0] gid;
    mop_t       nop;
    if (rst) begin
      pipe.delete();
      for (int i = 0; i < 4; i++) mtbl[i] = 7'h7F;
      mptr = '0;
      mcnt = '0;
    end else begin
      exp_rv = (pipe.size() > 0) && pipe[0].out;
      drain  = exp_rv && rsp_ready;
      allow  = !(pipe.size() == 2 && !drain);
      eg = '0; gid = '0; found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        logic [1:0] j;
        j = mptr + 2'(k);
        if (allow && !found && req_valid[j]) begin
          eg[j] = 1'b1; gid = j; found = 1'b1;
        end
      end
      chk("m_req_ready", 32'(req_ready), 32'(eg));
      chk("m_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv) begin
        chk("m_rsp_id",  32'(rsp_id),  32'(pipe[0].id));
        chk("m_rsp_dat", 32'(rsp_dat), 32'(ercm8(pipe[0].a, pipe[0].b, pipe[0].m)));
      end
      chk("m_op_cnt", 32'(op_cnt), 32'(mcnt));
      if (pipe.size() > 0 && !pipe[pipe.size()-1].out) begin
        chk("m_mul_a",    32'(mul_a),    32'(pipe[pipe.size()-1].a));
        chk("m_mul_b",    32'(mul_b),    32'(pipe[pipe.size()-1].b));
        chk("m_mul_mask", 32'(mul_mask), 32'(pipe[pipe.size()-1].m));
      end
      if (drain) begin
        void'(pipe.pop_front());
        mcnt = mcnt + 16'd1;
      end
      if (pipe.size() > 0) pipe[0].out = 1'b1;
      if (found) begin
        nop.id = gid; nop.a = op_a[gid]; nop.b = op_b[gid]; nop.m = mtbl[gid]; nop.out = 1'b0;
        pipe.push_back(nop);
        mptr = gid + 2'd1;
      end
      if (cfg_we) mtbl[cfg_id] = cfg_mask;
    end
  end

  // One cycle: apply inputs after the edge, refresh operands of last cycle's accepts,
  // then return at the falling edge with this cycle's accepts in acc.
  task automatic drive(input logic [3:0] vm, input logic rdy, input logic we = 1'b0,
                       input logic [1:0] id = 2'd0, input logic [6:0] m = 7'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++)
      if (acc[i]) begin op_a[i] = 8'($urandom); op_b[i] = 8'($urandom); end
    req_valid = vm; rsp_ready = rdy; cfg_we = we; cfg_id = id; cfg_mask = m;
    @(negedge clk);
    acc = req_valid & req_ready;
  endtask

  task automatic rst_pulse();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0; cfg_we = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    acc = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ea0, eb0, ea1, eb1;
    int accepted, cyc;

    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_op_cnt",    32'(op_cnt),    32'd0);
    chk("rst_mul_mask",  32'(mul_mask),  32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);

    // single op
    op_a[0] = 8'd13; op_b[0] = 8'd11;
    drive(4'b0001, 1'b1);
    chk("t1_grant", 32'(req_ready), 32'h1);
    drive(4'b0000, 1'b1);
    chk("t1_mul_a", 32'(mul_a), 32'd13);
    chk("t1_mul_mask", 32'(mul_mask), 32'h7F);
    chk("t1_no_rsp_yet", 32'(rsp_valid), 32'd0);
    drive(4'b0000, 1'b1);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_id", 32'(rsp_id), 32'd0);
    chk("t1_rsp_dat", 32'(rsp_dat), 32'd143);
    drive(4'b0000, 1'b1);
    chk("t1_op_cnt", 32'(op_cnt), 32'd1);

    // round robin
    rst_pulse();
    for (int i = 0; i < 4; i++) begin op_a[i] = 8'($urandom); op_b[i] = 8'($urandom); end
    for (int k = 0; k < 8; k++) begin
      drive(4'b1111, 1'b1);
      chk("t2_order", 32'(req_ready), 32'(4'b0001 << (k % 4)));
    end
    repeat (3) drive(4'b0000, 1'b1);
    chk("t2_op_cnt", 32'(op_cnt), 32'd8);

    // backpressure with a full pipe
    ea0 = op_a[0]; eb0 = op_b[0]; ea1 = op_a[1]; eb1 = op_b[1];
    drive(4'b1111, 1'b0);
    chk("t3_acc0", 32'(req_ready), 32'h1);
    drive(4'b1111, 1'b0);
    chk("t3_acc1", 32'(req_ready), 32'h2);
    for (int k = 0; k < 5; k++) begin
      drive(4'b1111, 1'b0);
      chk("t3_stall_ready", 32'(req_ready), 32'd0);
      chk("t3_stall_valid", 32'(rsp_valid), 32'd1);
      chk("t3_stall_id",    32'(rsp_id),    32'd0);
      chk("t3_stall_dat",   32'(rsp_dat),   32'(ercm8(ea0, eb0, 7'h7F)));
    end
    drive(4'b0000, 1'b1);
    chk("t3_rel0_valid", 32'(rsp_valid), 32'd1);
    chk("t3_rel0_id",    32'(rsp_id),    32'd0);
    drive(4'b0000, 1'b1);
    chk("t3_rel1_valid", 32'(rsp_valid), 32'd1);
    chk("t3_rel1_id",    32'(rsp_id),    32'd1);
    chk("t3_rel1_dat",   32'(rsp_dat),   32'(ercm8(ea1, eb1, 7'h7F)));
    drive(4'b0000, 1'b1);
    chk("t3_empty", 32'(rsp_valid), 32'd0);
    chk("t3_op_cnt", 32'(op_cnt), 32'd10);

    // config write racing an accept of the same entry
    op_a[1] = 8'hFF; op_b[1] = 8'hFF;
    drive(4'b0010, 1'b1, 1'b1, 2'd1, 7'h00);
    chk("t4_grant_old", 32'(req_ready), 32'h2);
    drive(4'b0000, 1'b1);
    chk("t4_old_mask", 32'(mul_mask), 32'h7F);
    drive(4'b0000, 1'b1);
    chk("t4_old_dat", 32'(rsp_dat), 32'hFE01);
    op_a[1] = 8'hFF; op_b[1] = 8'hFF;
    drive(4'b0010, 1'b1);
    chk("t4_grant_new", 32'(req_ready), 32'h2);
    drive(4'b0000, 1'b1);
    chk("t4_new_mask", 32'(mul_mask), 32'h00);
    drive(4'b0000, 1'b1);
    chk("t4_new_dat", 32'(rsp_dat), 32'hFE00);

    // reset with both stages occupied
    drive(4'b1111, 1'b0);
    drive(4'b1111, 1'b0);
    drive(4'b0000, 1'b0);
    chk("t5_full", 32'(rsp_valid), 32'd1);
    #2; rst = 1'b1; req_valid = '0;
    #1;
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_op_cnt",    32'(op_cnt),    32'd0);
    chk("t5_mul_mask",  32'(mul_mask),  32'd0);
    @(posedge clk); #1; rst = 1'b0; acc = '0;
    @(negedge clk);
    drive(4'b1111, 1'b1);
    chk("t5_ptr0", 32'(req_ready), 32'h1);
    drive(4'b0010, 1'b1);
    chk("t5_mask0", 32'(mul_mask), 32'h7F);
    drive(4'b0000, 1'b1);
    chk("t5_mask1", 32'(mul_mask), 32'h7F);

    // random traffic
    rst_pulse();
    accepted = 0; cyc = 0;
    while (accepted < 10000 && cyc < 40000) begin
      logic [3:0] vm;
      for (int i = 0; i < 4; i++)
        vm[i] = (req_valid[i] && !acc[i]) ? 1'b1 : ($urandom_range(0, 1) == 1);
      drive(vm, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            2'($urandom_range(0, 3)), 7'($urandom));
      accepted += $countones(acc);
      cyc++;
    end
    chk("t6_done", 32'(accepted >= 10000), 32'd1);
    repeat (4) drive(4'b0000, 1'b1);
    chk("t6_op_cnt", 32'(op_cnt), 32'(accepted));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
